operand_fetch_stage: RTL

- Registered operand-fetch pipeline stage between instruction fetch and execute.
- Decodes opcode[31:27], drives the register-file read addresses and read enable, and tracks pending register writes in a scoreboard.
- Stalls fetch on RAW/WAW hazards and hands the decoded instruction to execute over a valid/ready handshake.
- Generalises the combinational address mux to parametrised widths, with sequential hazard handling.

---
 rtl/operand_fetch_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: decodes the opcode, drives regfile read addresses and holds the accepted
// instruction for execute. Define OPFETCH_SCOREBOARD_EN to enable the RAW/WAW scoreboard stall.
module operand_fetch_stage #(
  parameter int DWIDTH  = 32,
  parameter int MWIDTH  = 5,
  parameter int OPWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] in_instr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [MWIDTH-1:0] addr_1,
  output logic [MWIDTH-1:0] addr_2,
  output logic              read_en,
  output logic [DWIDTH-1:0] out_instr,
  output logic [MWIDTH-1:0] out_dst,
  output logic              out_wr_en,
  output logic              out_illegal,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              wb_en,
  input  logic [MWIDTH-1:0] wb_addr
);

  localparam logic [OPWIDTH-1:0] OP_SW  = OPWIDTH'(1);
  localparam logic [OPWIDTH-1:0] OP_CMP = OPWIDTH'(11);
  localparam logic [OPWIDTH-1:0] OP_NOT = OPWIDTH'(12);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [OPWIDTH-1:0] opcode_s;
  logic               legal_s;
  logic               writer_s;
  logic               hazard_s;
  logic               accept_s;

  assign opcode_s = in_instr[DWIDTH-1 -: OPWIDTH];
  assign addr_1   = in_instr[DWIDTH-OPWIDTH-1 -: MWIDTH];
  assign addr_2   = in_instr[MWIDTH-1:0];

  // Opcode classification: legality and whether the instruction writes addr_1.
  always_comb begin
    legal_s  = 1'b0;
    writer_s = 1'b0;
    case (opcode_s)
      OP_SW, OP_CMP: begin
        legal_s  = 1'b1;
        writer_s = 1'b0;
      end
      default: begin
        legal_s  = (opcode_s <= OP_NOT);
        writer_s = (opcode_s <= OP_NOT);
      end
    endcase
  end

`ifdef OPFETCH_SCOREBOARD_EN
  localparam int SBW = 1 << MWIDTH;

  logic [SBW-1:0] sb_r;
  logic [SBW-1:0] sb_wb_s;
  logic [SBW-1:0] sb_next_s;

  // Writeback clear is applied before the hazard check so a same-cycle release bypasses the stall.
  always_comb begin
    sb_wb_s = sb_r;
    if (wb_en) begin
      sb_wb_s[wb_addr] = 1'b0;
    end else begin
      sb_wb_s = sb_r;
    end
  end

  // A busy destination (addr_1) also covers WAW ordering.
  always_comb begin
    hazard_s = in_valid & legal_s & (sb_wb_s[addr_1] | sb_wb_s[addr_2]);
  end

  // Set after clear, so a register released and re-claimed in one cycle stays busy.
  always_comb begin
    sb_next_s = sb_wb_s;
    if (accept_s && writer_s) begin
      sb_next_s[addr_1] = 1'b1;
    end else begin
      sb_next_s = sb_wb_s;
    end
  end

  // Scoreboard of registers with an outstanding write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_r <= '0;
    end else begin
      sb_r <= sb_next_s;
    end
  end
`else
  logic unused_wb_s;

  assign unused_wb_s = ^{wb_en, wb_addr};
  assign hazard_s    = 1'b0;
`endif

  assign in_ready = (~out_valid | out_ready) & ~hazard_s;
  assign accept_s = in_valid & in_ready;
  assign read_en  = accept_s & legal_s;
  assign out_valid = (state_r == FULL);

  // Output stage occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Output stage next state.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          next_state_s = FULL;
        end else begin
          next_state_s = EMPTY;
        end
      end
      FULL: begin
        if (out_ready && !accept_s) begin
          next_state_s = EMPTY;
        end else begin
          next_state_s = FULL;
        end
      end
      default: next_state_s = EMPTY;
    endcase
  end

  // Output payload loads only on accept, so it holds while execute back-pressures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_instr   <= '0;
      out_dst     <= '0;
      out_wr_en   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (accept_s) begin
      out_instr   <= in_instr;
      out_dst     <= addr_1;
      out_wr_en   <= writer_s;
      out_illegal <= ~legal_s;
    end else begin
      out_instr   <= out_instr;
      out_dst     <= out_dst;
      out_wr_en   <= out_wr_en;
      out_illegal <= out_illegal;
    end
  end

endmodule
